// File: rtl/neosd_clk_sched.sv
// neosd_clk_sched: SD clock scheduler for the neosd controller.
//
// Arbitrates SD clock requests from the command and data FSMs and generates
// sd_clk_o from the clkgen tick selected by the divider select. It produces
// rise/fall strobes, pauses the clock for data-buffer flow control, and issues
// IDLE_CLKS trailing idle clocks (Ncc) before stopping.
//
// Ports:
//   clk_i        system clock
//   rstn_i       asynchronous active-low reset
//   clkgen_i     clkgen tick pulses, one per divider setting
//   cdiv_i       divider select, sampled only while stopped
//   en_i         controller enable; low aborts immediately
//   cmd_req_i    command FSM needs the clock
//   dat_req_i    data FSM needs the clock
//   dat_hold_i   data buffer full/empty, pauses the clock while data is active
//   sd_clk_o     SD card clock
//   strb_rise_o  one-cycle pulse in the cycle sd_clk_o has just risen
//   strb_fall_o  one-cycle pulse in the cycle sd_clk_o has just fallen
//   running_o    scheduler not stopped
//   paused_o     scheduler paused for flow control
module neosd_clk_sched #(
    parameter int unsigned IDLE_CLKS = 8
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic [7:0] clkgen_i,
    input  logic [2:0] cdiv_i,
    input  logic       en_i,
    input  logic       cmd_req_i,
    input  logic       dat_req_i,
    input  logic       dat_hold_i,
    output logic       sd_clk_o,
    output logic       strb_rise_o,
    output logic       strb_fall_o,
    output logic       running_o,
    output logic       paused_o
);

    typedef enum logic [1:0] {StStop, StRun, StPause, StTrail} state_e;

    localparam logic [3:0] IdleCnt = 4'(IDLE_CLKS);

    state_e     state_q;
    logic [2:0] cdiv_q;
    logic [3:0] trail_cnt_q;
    logic       sd_clk_q;
    logic       rise_q;
    logic       fall_q;

    logic tick;
    logic req;
    logic hold;

    // Divider is frozen outside STOP so a running clock never changes period.
    assign tick = clkgen_i[cdiv_q];
    assign req  = en_i & (cmd_req_i | dat_req_i);
    assign hold = dat_hold_i & dat_req_i;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= StStop;
            cdiv_q      <= 3'd0;
            trail_cnt_q <= 4'd0;
            sd_clk_q    <= 1'b0;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            if (state_q == StStop) begin
                cdiv_q <= cdiv_i;
            end

            if (!en_i) begin
                // Abort: clock drops without a fall strobe.
                state_q     <= StStop;
                sd_clk_q    <= 1'b0;
                trail_cnt_q <= 4'd0;
            end else if (tick) begin
                unique case (state_q)
                    StStop: begin
                        if (req && !hold) begin
                            sd_clk_q <= 1'b1;
                            rise_q   <= 1'b1;
                            state_q  <= StRun;
                        end
                    end
                    StRun: begin
                        if (sd_clk_q) begin
                            sd_clk_q <= 1'b0;
                            fall_q   <= 1'b1;
                        end else if (hold) begin
                            state_q <= StPause;
                        end else if (!req) begin
                            if (IdleCnt == 4'd0) begin
                                state_q <= StStop;
                            end else begin
                                state_q     <= StTrail;
                                trail_cnt_q <= IdleCnt;
                            end
                        end else begin
                            sd_clk_q <= 1'b1;
                            rise_q   <= 1'b1;
                        end
                    end
                    StPause: begin
                        if (!req) begin
                            if (IdleCnt == 4'd0) begin
                                state_q <= StStop;
                            end else begin
                                state_q     <= StTrail;
                                trail_cnt_q <= IdleCnt;
                            end
                        end else if (!hold) begin
                            sd_clk_q <= 1'b1;
                            rise_q   <= 1'b1;
                            state_q  <= StRun;
                        end
                    end
                    StTrail: begin
                        if (sd_clk_q) begin
                            sd_clk_q <= 1'b0;
                            fall_q   <= 1'b1;
                            // Count trailing periods on the falling edge.
                            if (trail_cnt_q <= 4'd1) begin
                                state_q     <= StStop;
                                trail_cnt_q <= 4'd0;
                            end else begin
                                trail_cnt_q <= trail_cnt_q - 4'd1;
                            end
                        end else if (req) begin
                            sd_clk_q    <= 1'b1;
                            rise_q      <= 1'b1;
                            state_q     <= StRun;
                            trail_cnt_q <= 4'd0;
                        end else begin
                            sd_clk_q <= 1'b1;
                            rise_q   <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= StStop;
                    end
                endcase
            end
        end
    end

    assign sd_clk_o    = sd_clk_q;
    assign strb_rise_o = rise_q;
    assign strb_fall_o = fall_q;
    assign running_o   = (state_q != StStop);
    assign paused_o    = (state_q == StPause);

endmodule

// File: tb/tb_neosd_clk_sched.sv
// Directed bench for neosd_clk_sched; a second instance with IDLE_CLKS=0
// shares all inputs to cover the no-trailing-clock case.
module tb_neosd_clk_sched;

    logic       clk = 1'b0;
    logic       rstn;
    logic [7:0] clkgen;
    logic [2:0] cdiv;
    logic       en;
    logic       cmd_req;
    logic       dat_req;
    logic       dat_hold;

    logic sd_clk, strb_rise, strb_fall, running, paused;
    logic sd_clk0, strb_rise0, strb_fall0, running0, paused0;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int          gen_cnt  = 0;
    bit          div_mode = 1'b0;
    logic        prev_sd  = 1'b0;
    int          edge_err = 0;
    int          rise0_cnt = 0;

    always #5 clk = ~clk;

    neosd_clk_sched #(.IDLE_CLKS(8)) dut (
        .clk_i      (clk),
        .rstn_i     (rstn),
        .clkgen_i   (clkgen),
        .cdiv_i     (cdiv),
        .en_i       (en),
        .cmd_req_i  (cmd_req),
        .dat_req_i  (dat_req),
        .dat_hold_i (dat_hold),
        .sd_clk_o   (sd_clk),
        .strb_rise_o(strb_rise),
        .strb_fall_o(strb_fall),
        .running_o  (running),
        .paused_o   (paused)
    );

    neosd_clk_sched #(.IDLE_CLKS(0)) dut0 (
        .clk_i      (clk),
        .rstn_i     (rstn),
        .clkgen_i   (clkgen),
        .cdiv_i     (cdiv),
        .en_i       (en),
        .cmd_req_i  (cmd_req),
        .dat_req_i  (dat_req),
        .dat_hold_i (dat_hold),
        .sd_clk_o   (sd_clk0),
        .strb_rise_o(strb_rise0),
        .strb_fall_o(strb_fall0),
        .running_o  (running0),
        .paused_o   (paused0)
    );

    // One clock cycle: sample 1 time unit after the edge, track strobe/edge
    // consistency, then advance the clkgen pattern.
    task automatic step();
        @(posedge clk);
        #1;
        if (strb_rise !== (sd_clk === 1'b1 && prev_sd === 1'b0)) edge_err++;
        if (strb_fall === 1'b1 && !(prev_sd === 1'b1 && sd_clk === 1'b0)) edge_err++;
        if (prev_sd === 1'b1 && sd_clk === 1'b0 && strb_fall !== 1'b1 && running === 1'b1)
            edge_err++;
        prev_sd = sd_clk;
        if (strb_rise0 === 1'b1) rise0_cnt++;
        gen_cnt++;
        if (div_mode) begin
            for (int n = 0; n < 8; n++) begin
                int mask;
                mask = (1 << (n + 1)) - 1;
                clkgen[n] = ((gen_cnt & mask) == mask);
            end
        end else begin
            clkgen = 8'hFF;
        end
    endtask

    task automatic wait_rise(input int bound, output int cyc, output bit ok);
        ok  = 1'b0;
        cyc = 0;
        for (int i = 0; i < bound; i++) begin
            step();
            cyc++;
            if (strb_rise === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_stop(input int bound, output bit ok, output int rises,
                             output int falls);
        ok    = 1'b0;
        rises = 0;
        falls = 0;
        for (int i = 0; i < bound; i++) begin
            step();
            if (strb_rise === 1'b1) rises++;
            if (strb_fall === 1'b1) falls++;
            if (running === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; clkgen = 8'hFF; cdiv = 3'd0; en = 1'b0;
        cmd_req = 1'b0; dat_req = 1'b0; dat_hold = 1'b0;
        #12;
        n_checks++;
        if (sd_clk !== 1'b0) $display("FAIL reset_sd_clk: got %b want 0", sd_clk);
        else n_pass++;
        n_checks++;
        if ({strb_rise, strb_fall} !== 2'b00)
            $display("FAIL reset_strobes: got %b want 00", {strb_rise, strb_fall});
        else n_pass++;
        n_checks++;
        if (running !== 1'b0) $display("FAIL reset_running: got %b want 0", running);
        else n_pass++;
        n_checks++;
        if (paused !== 1'b0) $display("FAIL reset_paused: got %b want 0", paused);
        else n_pass++;
        n_checks++;
        if (running0 !== 1'b0) $display("FAIL reset_running0: got %b want 0", running0);
        else n_pass++;
        @(negedge clk);
        rstn = 1'b1;
        step();
    endtask

    task automatic test_basic();
        int  rises, falls, tr, tf;
        bit  ok;
        rises = 0; falls = 0;
        en = 1'b1; cdiv = 3'd0; cmd_req = 1'b1;
        repeat (20) begin
            step();
            if (strb_rise === 1'b1) rises++;
            if (strb_fall === 1'b1) falls++;
        end
        n_checks++;
        if (rises != 10) $display("FAIL basic_rises: got %0d want 10", rises);
        else n_pass++;
        n_checks++;
        if (falls != 10) $display("FAIL basic_falls: got %0d want 10", falls);
        else n_pass++;
        cmd_req = 1'b0;
        wait_stop(40, ok, tr, tf);
        n_checks++;
        if (!ok) $display("FAIL basic_stop: got running=%b want 0", running);
        else n_pass++;
        n_checks++;
        if (tr != 8) $display("FAIL basic_trail_rises: got %0d want 8", tr);
        else n_pass++;
        n_checks++;
        if (tf != 8) $display("FAIL basic_trail_falls: got %0d want 8", tf);
        else n_pass++;
        n_checks++;
        if (sd_clk !== 1'b0) $display("FAIL basic_final_clk: got %b want 0", sd_clk);
        else n_pass++;
    endtask

    task automatic test_idle_zero();
        int base, tr, tf;
        bit ok;
        cmd_req = 1'b1;
        repeat (6) step();
        base = rise0_cnt;
        cmd_req = 1'b0;
        repeat (2) step();
        n_checks++;
        if ({running0, sd_clk0} !== 2'b00)
            $display("FAIL idle0_stop: got running0/sd_clk0=%b want 00", {running0, sd_clk0});
        else n_pass++;
        n_checks++;
        if (running !== 1'b1) $display("FAIL idle8_trailing: got running=%b want 1", running);
        else n_pass++;
        wait_stop(40, ok, tr, tf);
        n_checks++;
        if (rise0_cnt - base != 0)
            $display("FAIL idle0_trail_rises: got %0d want 0", rise0_cnt - base);
        else n_pass++;
    endtask

    task automatic test_cdiv();
        int cyc, tr, tf;
        bit ok;
        div_mode = 1'b1; cdiv = 3'd3;
        repeat (2) step();
        dat_req = 1'b1;
        wait_rise(40, cyc, ok);
        wait_rise(40, cyc, ok);
        n_checks++;
        if (!ok || cyc != 32) $display("FAIL cdiv3_period: got %0d want 32", cyc);
        else n_pass++;
        cdiv = 3'd1;
        wait_rise(40, cyc, ok);
        n_checks++;
        if (!ok || cyc != 32) $display("FAIL cdiv_frozen_period: got %0d want 32", cyc);
        else n_pass++;
        dat_req = 1'b0;
        wait_stop(400, ok, tr, tf);
        n_checks++;
        if (!ok) $display("FAIL cdiv_stop: got running=%b want 0", running);
        else n_pass++;
        step();
        dat_req = 1'b1;
        wait_rise(20, cyc, ok);
        wait_rise(20, cyc, ok);
        n_checks++;
        if (!ok || cyc != 8) $display("FAIL cdiv1_period: got %0d want 8", cyc);
        else n_pass++;
        dat_req = 1'b0;
        wait_stop(100, ok, tr, tf);
        div_mode = 1'b0;
        step();
    endtask

    task automatic test_hold();
        int cyc, strobes, highs, tr, tf;
        bit ok;
        strobes = 0; highs = 0;
        dat_req = 1'b1;
        wait_rise(5, cyc, ok);
        dat_hold = 1'b1;
        step();
        n_checks++;
        if ({sd_clk, strb_fall} !== 2'b01)
            $display("FAIL hold_fall: got sd_clk/fall=%b want 01", {sd_clk, strb_fall});
        else n_pass++;
        step();
        n_checks++;
        if ({paused, running, sd_clk, strb_rise, strb_fall} !== 5'b11000)
            $display("FAIL hold_pause: got %b want 11000",
                     {paused, running, sd_clk, strb_rise, strb_fall});
        else n_pass++;
        repeat (10) begin
            step();
            if (strb_rise === 1'b1 || strb_fall === 1'b1) strobes++;
            if (sd_clk !== 1'b0) highs++;
        end
        n_checks++;
        if (strobes != 0 || highs != 0)
            $display("FAIL hold_quiet: got strobes=%0d highs=%0d want 0 0", strobes, highs);
        else n_pass++;
        n_checks++;
        if (paused !== 1'b1) $display("FAIL hold_still_paused: got %b want 1", paused);
        else n_pass++;
        dat_hold = 1'b0;
        step();
        n_checks++;
        if ({sd_clk, strb_rise, paused} !== 3'b110)
            $display("FAIL hold_release: got sd/rise/paused=%b want 110",
                     {sd_clk, strb_rise, paused});
        else n_pass++;
        dat_req = 1'b0;
        wait_stop(40, ok, tr, tf);
    endtask

    task automatic test_trail_restart();
        int cyc, falls, tr, tf;
        bit ok;
        falls = 0;
        cmd_req = 1'b1;
        wait_rise(5, cyc, ok);
        cmd_req = 1'b0;
        // One RUN fall plus five trailing falls leaves three clocks to go.
        for (int i = 0; i < 30 && falls < 6; i++) begin
            step();
            if (strb_fall === 1'b1) falls++;
        end
        n_checks++;
        if (falls != 6 || running !== 1'b1 || sd_clk !== 1'b0)
            $display("FAIL trail_reach: got falls=%0d running=%b sd=%b want 6 1 0",
                     falls, running, sd_clk);
        else n_pass++;
        cmd_req = 1'b1;
        step();
        n_checks++;
        if ({sd_clk, strb_rise, running} !== 3'b111)
            $display("FAIL trail_resume: got sd/rise/running=%b want 111",
                     {sd_clk, strb_rise, running});
        else n_pass++;
        repeat (4) step();
        cmd_req = 1'b0;
        wait_stop(40, ok, tr, tf);
        n_checks++;
        if (!ok || tr != 8) $display("FAIL trail_restart_rises: got %0d want 8", tr);
        else n_pass++;
    endtask

    task automatic test_abort();
        int cyc, tr, tf;
        bit ok;
        cmd_req = 1'b1;
        wait_rise(5, cyc, ok);
        en = 1'b0;
        step();
        n_checks++;
        if (sd_clk !== 1'b0) $display("FAIL abort_clk: got %b want 0", sd_clk);
        else n_pass++;
        n_checks++;
        if ({strb_rise, strb_fall} !== 2'b00)
            $display("FAIL abort_strobes: got %b want 00", {strb_rise, strb_fall});
        else n_pass++;
        n_checks++;
        if (running !== 1'b0) $display("FAIL abort_running: got %b want 0", running);
        else n_pass++;
        en = 1'b1;
        step();
        n_checks++;
        if ({sd_clk, strb_rise, running} !== 3'b111)
            $display("FAIL abort_restart: got sd/rise/running=%b want 111",
                     {sd_clk, strb_rise, running});
        else n_pass++;
        cmd_req = 1'b0;
        wait_stop(40, ok, tr, tf);
    endtask

    task automatic test_async_reset();
        int cyc;
        bit ok;
        cmd_req = 1'b1;
        wait_rise(5, cyc, ok);
        #2;
        rstn = 1'b0;
        #1;
        n_checks++;
        if ({sd_clk, strb_rise, strb_fall, running, paused} !== 5'b00000)
            $display("FAIL areset_dut: got %b want 00000",
                     {sd_clk, strb_rise, strb_fall, running, paused});
        else n_pass++;
        n_checks++;
        if ({sd_clk0, strb_rise0, running0} !== 3'b000)
            $display("FAIL areset_dut0: got %b want 000", {sd_clk0, strb_rise0, running0});
        else n_pass++;
        cmd_req = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        prev_sd = 1'b0;
        repeat (2) step();
        n_checks++;
        if ({running, sd_clk} !== 2'b00)
            $display("FAIL areset_idle: got running/sd=%b want 00", {running, sd_clk});
        else n_pass++;
    endtask

    task automatic test_strobes();
        n_checks++;
        if (edge_err != 0) $display("FAIL strobe_edge_match: got %0d errors want 0", edge_err);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_idle_zero();
        test_cdiv();
        test_hold();
        test_trail_restart();
        test_abort();
        test_async_reset();
        test_strobes();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
